mips_multicycle_ctrl_v2: RTL and testbench

Parametrised main controller for the multicycle MIPS datapath, the successor to the fixed single-step controller. It adds a run/single-step mode switch with a synchronised step button and a memory-ready handshake on fetch, load and store. It extends the ISA with BNE, ANDI, ORI, SLTI and JAL, plus an illegal-opcode halt state and cycle/instruction performance counters. It sits between the instruction register (opcode source) and the datapath mux/enable inputs; State_Out drives the board LEDs.

---
 rtl/mips_multicycle_ctrl_v2_if.sv | 54 +++++
 rtl/mips_multicycle_ctrl_v2.sv | 224 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl_v2.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_v2_if.sv
// ============================================================================
// Module   : mips_multicycle_ctrl_v2_if
// Brief    : Control/status bundle between the multicycle controller and datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mips_multicycle_ctrl_v2_if #(
    parameter int CNT_W = 16
);
    logic             Run;
    logic             Step_btn;
    logic [5:0]       Opcode;
    logic             Mem_Ready;

    logic [3:0]       State_Out;
    logic             Read_reg;
    logic             IorD_Out;
    logic             AluSrcA_Out;
    logic             IRWrite_Out;
    logic             PCWrite_Out;
    logic             RegWrite_Out;
    logic             MemWrite_Out;
    logic             Branch_Out;
    logic             BranchNe_Out;
    logic             ZeroExt_Out;
    logic [1:0]       AluSrcB_Out;
    logic [1:0]       PCSrc_Out;
    logic [1:0]       RegDest_Out;
    logic [1:0]       MemtoReg_Out;
    logic [2:0]       ALUOp_Out;
    logic             Halted;
    logic             Illegal_Opcode;
    logic [CNT_W-1:0] Cycle_Count;
    logic [CNT_W-1:0] Instr_Count;

    modport master (
        input  Run, Step_btn, Opcode, Mem_Ready,
        output State_Out, Read_reg, IorD_Out, AluSrcA_Out, IRWrite_Out, PCWrite_Out,
               RegWrite_Out, MemWrite_Out, Branch_Out, BranchNe_Out, ZeroExt_Out,
               AluSrcB_Out, PCSrc_Out, RegDest_Out, MemtoReg_Out, ALUOp_Out,
               Halted, Illegal_Opcode, Cycle_Count, Instr_Count
    );

    modport slave (
        output Run, Step_btn, Opcode, Mem_Ready,
        input  State_Out, Read_reg, IorD_Out, AluSrcA_Out, IRWrite_Out, PCWrite_Out,
               RegWrite_Out, MemWrite_Out, Branch_Out, BranchNe_Out, ZeroExt_Out,
               AluSrcB_Out, PCSrc_Out, RegDest_Out, MemtoReg_Out, ALUOp_Out,
               Halted, Illegal_Opcode, Cycle_Count, Instr_Count
    );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_v2.sv
// ============================================================================
// Module   : mips_multicycle_ctrl_v2
// Brief    : Multicycle MIPS main controller with run/step, memory handshake,
//            illegal-opcode halt and cycle/instruction counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl_v2 #(
    parameter int CNT_W         = 16,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  wire logic                   clk,
    input  wire logic                   Reset_n,
    mips_multicycle_ctrl_v2_if.master   bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADR    = 4'd2,
        MEMREAD   = 4'd3,
        MEMWB     = 4'd4,
        MEMWRITE  = 4'd5,
        EXECUTE   = 4'd6,
        ALUWB     = 4'd7,
        BRANCH    = 4'd8,
        IMMEXEC   = 4'd9,
        IMMWB     = 4'd10,
        JUMP      = 4'd11,
        STEP_WAIT = 4'd12,
        JAL       = 4'd13,
        HALT      = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t           state;
    state_t           next_state;
    logic             rdy;
    logic             term_exit;
    logic             decode_illegal;
    logic             step_sync1;
    logic             step_sync2;
    logic             step_prev;
    logic             step_pulse;
    logic             illegal;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    generate
        if (MEM_HANDSHAKE) begin : g_handshake
            assign rdy = bus.Mem_Ready;
        end else begin : g_no_handshake
            assign rdy = 1'b1;
        end
    endgenerate

    assign step_pulse = step_sync2 & ~step_prev;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= STEP_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state        = state;
        term_exit         = 1'b0;
        decode_illegal    = 1'b0;
        bus.Read_reg      = 1'b0;
        bus.IorD_Out      = 1'b0;
        bus.AluSrcA_Out   = 1'b0;
        bus.IRWrite_Out   = 1'b0;
        bus.PCWrite_Out   = 1'b0;
        bus.RegWrite_Out  = 1'b0;
        bus.MemWrite_Out  = 1'b0;
        bus.Branch_Out    = 1'b0;
        bus.BranchNe_Out  = 1'b0;
        bus.ZeroExt_Out   = 1'b0;
        bus.AluSrcB_Out   = 2'b00;
        bus.PCSrc_Out     = 2'b00;
        bus.RegDest_Out   = 2'b00;
        bus.MemtoReg_Out  = 2'b00;
        bus.ALUOp_Out     = 3'b000;
        bus.Halted        = 1'b0;
        case (state)
            FETCH: begin
                bus.AluSrcB_Out = 2'b01;
                bus.IRWrite_Out = rdy;
                bus.PCWrite_Out = rdy;
                if (rdy) next_state = DECODE;
            end
            DECODE: begin
                bus.AluSrcB_Out = 2'b11;
                case (bus.Opcode)
                    OP_LW, OP_SW:                      next_state = MEMADR;
                    OP_RTYPE:                          next_state = EXECUTE;
                    OP_BEQ, OP_BNE:                    next_state = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = IMMEXEC;
                    OP_J:                              next_state = JUMP;
                    OP_JAL:                            next_state = JAL;
                    default: begin
                        next_state     = HALT;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.AluSrcA_Out = 1'b1;
                bus.AluSrcB_Out = 2'b10;
                next_state      = (bus.Opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.IorD_Out = 1'b1;
                if (rdy) next_state = MEMWB;
            end
            MEMWB: begin
                bus.RegWrite_Out = 1'b1;
                bus.MemtoReg_Out = 2'b01;
                term_exit        = 1'b1;
            end
            MEMWRITE: begin
                bus.IorD_Out     = 1'b1;
                bus.MemWrite_Out = 1'b1;
                term_exit        = rdy;
            end
            EXECUTE: begin
                bus.AluSrcA_Out = 1'b1;
                bus.ALUOp_Out   = 3'b010;
                next_state      = ALUWB;
            end
            ALUWB: begin
                bus.RegDest_Out  = 2'b01;
                bus.RegWrite_Out = 1'b1;
                term_exit        = 1'b1;
            end
            BRANCH: begin
                bus.AluSrcA_Out  = 1'b1;
                bus.ALUOp_Out    = 3'b001;
                bus.PCSrc_Out    = 2'b01;
                bus.Branch_Out   = (bus.Opcode == OP_BEQ);
                bus.BranchNe_Out = (bus.Opcode == OP_BNE);
                term_exit        = 1'b1;
            end
            IMMEXEC: begin
                bus.AluSrcA_Out = 1'b1;
                bus.AluSrcB_Out = 2'b10;
                case (bus.Opcode)
                    OP_ANDI: bus.ALUOp_Out = 3'b011;
                    OP_ORI:  bus.ALUOp_Out = 3'b100;
                    OP_SLTI: bus.ALUOp_Out = 3'b101;
                    default: bus.ALUOp_Out = 3'b000;
                endcase
                bus.ZeroExt_Out = (bus.Opcode == OP_ANDI) || (bus.Opcode == OP_ORI);
                next_state      = IMMWB;
            end
            IMMWB: begin
                bus.RegWrite_Out = 1'b1;
                term_exit        = 1'b1;
            end
            JUMP: begin
                bus.PCSrc_Out   = 2'b10;
                bus.PCWrite_Out = 1'b1;
                term_exit       = 1'b1;
            end
            JAL: begin
                bus.PCSrc_Out    = 2'b10;
                bus.PCWrite_Out  = 1'b1;
                bus.RegWrite_Out = 1'b1;
                bus.RegDest_Out  = 2'b10;
                bus.MemtoReg_Out = 2'b10;
                term_exit        = 1'b1;
            end
            STEP_WAIT: begin
                bus.Read_reg = 1'b1;
                if (step_pulse || bus.Run) next_state = FETCH;
            end
            HALT: begin
                bus.Halted = 1'b1;
            end
            default: next_state = STEP_WAIT;
        endcase
        // Every terminal state shares the same run/step exit
        if (term_exit) next_state = bus.Run ? FETCH : STEP_WAIT;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            step_sync1 <= 1'b0;
            step_sync2 <= 1'b0;
            step_prev  <= 1'b0;
            illegal    <= 1'b0;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
        end else begin
            step_sync1 <= bus.Step_btn;
            step_sync2 <= step_sync1;
            step_prev  <= step_sync2;
            illegal    <= illegal | decode_illegal;
            if (state != STEP_WAIT && state != HALT) cycle_cnt <= cycle_cnt + 1'b1;
            if (term_exit) instr_cnt <= instr_cnt + 1'b1;
        end
    end

    assign bus.State_Out      = state;
    assign bus.Illegal_Opcode = illegal;
    assign bus.Cycle_Count    = cycle_cnt;
    assign bus.Instr_Count    = instr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl_v2.sv
// ============================================================================
// Module   : tb_mips_multicycle_ctrl_v2
// Brief    : Randomized bench for the multicycle controller against a path-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl_v2;
    localparam int CNT_W = 4;
    localparam int CMOD  = 1 << CNT_W;

    logic clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_v2_if #(.CNT_W(CNT_W)) bus ();

    mips_multicycle_ctrl_v2 #(.CNT_W(CNT_W), .MEM_HANDSHAKE(1'b1)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining state path of the current instruction
    int m_state;
    int m_path[$];
    int m_cyc;
    int m_ins;
    bit m_ill;
    bit hist [1:3];
    bit force_illegal = 1'b0;

    logic [5:0] legal_ops [11] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08,
                                   6'h0c, 6'h0d, 6'h0a, 6'h02, 6'h03};
    logic [5:0] bad_ops [3] = '{6'h3f, 6'h01, 6'h24};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [20:0] exp_ctrl(input int st, input logic [5:0] op, input logic rdy);
        logic rr, iord, asa, irw, pcw, rw, mw, br, bne, zx;
        logic [1:0] asb, pcs, rd, m2r;
        logic [2:0] aop;
        {rr, iord, asa, irw, pcw, rw, mw, br, bne, zx} = '0;
        {asb, pcs, rd, m2r, aop} = '0;
        case (st)
            0:  begin asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  iord = 1;
            4:  begin rw = 1; m2r = 2'b01; end
            5:  begin iord = 1; mw = 1; end
            6:  begin asa = 1; aop = 3'b010; end
            7:  begin rd = 2'b01; rw = 1; end
            8:  begin asa = 1; aop = 3'b001; pcs = 2'b01; br = (op == 6'h04); bne = (op == 6'h05); end
            9:  begin
                    asa = 1; asb = 2'b10;
                    aop = (op == 6'h0c) ? 3'b011 : (op == 6'h0d) ? 3'b100 :
                          (op == 6'h0a) ? 3'b101 : 3'b000;
                    zx  = (op == 6'h0c) || (op == 6'h0d);
                end
            10: rw = 1;
            11: begin pcs = 2'b10; pcw = 1; end
            12: rr = 1;
            13: begin pcs = 2'b10; pcw = 1; rw = 1; rd = 2'b10; m2r = 2'b10; end
            default: ;
        endcase
        return {rr, iord, asa, irw, pcw, rw, mw, br, bne, zx, asb, pcs, rd, m2r, aop};
    endfunction

    task automatic check_all();
        logic [20:0] got;
        got = {bus.Read_reg, bus.IorD_Out, bus.AluSrcA_Out, bus.IRWrite_Out, bus.PCWrite_Out,
               bus.RegWrite_Out, bus.MemWrite_Out, bus.Branch_Out, bus.BranchNe_Out,
               bus.ZeroExt_Out, bus.AluSrcB_Out, bus.PCSrc_Out, bus.RegDest_Out,
               bus.MemtoReg_Out, bus.ALUOp_Out};
        check_val("state",   bus.State_Out, m_state);
        check_val("ctrl",    got, exp_ctrl(m_state, bus.Opcode, bus.Mem_Ready));
        check_val("halted",  bus.Halted, (m_state == 14));
        check_val("illegal", bus.Illegal_Opcode, m_ill);
        check_val("cycles",  bus.Cycle_Count, m_cyc);
        check_val("instrs",  bus.Instr_Count, m_ins);
    endtask

    task automatic model_reset();
        m_state = 12;
        m_path.delete();
        m_cyc = 0;
        m_ins = 0;
        m_ill = 0;
        hist[1] = 0; hist[2] = 0; hist[3] = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample
    task automatic model_advance();
        bit pulse, run, rdy;
        logic [5:0] op;
        int nxt;
        pulse = hist[2] & ~hist[3];
        run   = bus.Run;
        rdy   = bus.Mem_Ready;
        op    = bus.Opcode;
        nxt   = m_state;
        if (m_state != 12 && m_state != 14) m_cyc = (m_cyc + 1) % CMOD;
        if (m_state == 12) begin
            if (run || pulse) nxt = 0;
        end else if (m_state != 14 && !((m_state == 0 || m_state == 3 || m_state == 5) && !rdy)) begin
            if (m_state == 0) nxt = 1;
            else if (m_state == 1) begin
                case (op)
                    6'h23:                      m_path = '{2, 3, 4};
                    6'h2b:                      m_path = '{2, 5};
                    6'h00:                      m_path = '{6, 7};
                    6'h04, 6'h05:               m_path = '{8};
                    6'h08, 6'h0c, 6'h0d, 6'h0a: m_path = '{9, 10};
                    6'h02:                      m_path = '{11};
                    6'h03:                      m_path = '{13};
                    default:                    m_path = '{14};
                endcase
                nxt = m_path.pop_front();
                if (nxt == 14) m_ill = 1;
            end else if (m_path.size() != 0) nxt = m_path.pop_front();
            else begin
                nxt   = run ? 0 : 12;
                m_ins = (m_ins + 1) % CMOD;
            end
        end
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = bus.Step_btn;
        m_state = nxt;
    endtask

    task automatic drive_random();
        if ($urandom_range(15) == 0) bus.Run = ~bus.Run;
        bus.Mem_Ready = ($urandom_range(3) != 0);
        if ($urandom_range(3) == 0) bus.Step_btn = ~bus.Step_btn;
        if (m_state == 0 || m_state == 12) begin
            if (force_illegal) bus.Opcode = bad_ops[$urandom_range(2)];
            else               bus.Opcode = legal_ops[$urandom_range(10)];
        end
    endtask

    // Entered and left at posedge+1
    task automatic one_cycle(input bit rnd);
        if (rnd) drive_random();
        #1;
        check_all();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_val("async_rst_state", bus.State_Out, 12);
        check_all();
        @(posedge clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        bus.Run       = 1'b1;
        bus.Mem_Ready = 1'b1;
        bus.Step_btn  = 1'b0;
        bus.Opcode    = 6'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        Reset_n = 1'b1;

        // R-type straight after reset: 12 -> 0,1,6,7 -> 0
        repeat (5) one_cycle(1'b0);
        check_val("rtype_state",  bus.State_Out, 0);
        check_val("rtype_cycles", bus.Cycle_Count, 4);
        check_val("rtype_instrs", bus.Instr_Count, 1);
        for (int i = 0; i < 10 && m_state != 6; i++) one_cycle(1'b0);
        check_val("reach_execute", bus.State_Out, 6);
        mid_reset();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199) == 0) mid_reset();
            else one_cycle(1'b1);
        end

        // Illegal opcode: halt, then frozen under random Run/Step_btn
        force_illegal = 1'b1;
        for (int i = 0; i < 300 && m_state != 14; i++) one_cycle(1'b1);
        check_val("halt_reached", bus.Halted, 1);
        repeat (20) one_cycle(1'b1);
        mid_reset();
        force_illegal = 1'b0;
        repeat (50) one_cycle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
